// File: rtl/sseg_scan_driver.sv
// Time-multiplexed seven-segment driver: scans DIGITS digits with PWM brightness,
// per-digit blanking, leading-zero suppression and frame-synchronous input capture.
module sseg_scan_driver #(
  parameter int DIGITS     = 8,
  parameter int PRESCALE   = 100000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [3:0]            brightness,
  output logic [6:0]            SSEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  DP,
  output logic                  frame_tick
);

  localparam int   SUB_N = PRESCALE / 16;
  localparam int   SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
  localparam int   IDX_W = $clog2(DIGITS);
  localparam logic INV   = (ACTIVE_LOW != 0);

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  logic [SUB_W-1:0]    sub_q, sub_d;
  logic [3:0]          slot_q, slot_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                new_frame_q, new_frame_d;
  logic                sub_wrap, slot_wrap, idx_wrap, capture;

  logic [4*DIGITS-1:0] shd_hex_q, hex_e;
  logic [DIGITS-1:0]   shd_dp_q, dp_e;
  logic [DIGITS-1:0]   shd_blank_q, blank_e;
  logic                shd_lz_q, lz_e;
  logic [3:0]          shd_br_q, br_e;

  logic [DIGITS-1:0]   sup;
  logic                run;
  logic [3:0]          cur_val;
  logic                lit;
  logic [DIGITS-1:0]   an_d, an_q;
  logic [6:0]          sseg_d, sseg_q;
  logic                dp_d, dp_q, ft_q;

  // new_frame_q marks a pending frame start; it is consumed only on an enabled cycle
  always_comb begin
    sub_wrap    = (sub_q == SUB_W'(SUB_N - 1));
    slot_wrap   = sub_wrap && (slot_q == 4'd15);
    idx_wrap    = slot_wrap && (idx_q == IDX_W'(DIGITS - 1));
    capture     = enable && new_frame_q;
    sub_d       = sub_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    new_frame_d = new_frame_q;
    if (enable) begin
      sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
      if (sub_wrap)  slot_d = slot_q + 4'd1;
      if (slot_wrap) idx_d  = idx_wrap ? '0 : idx_q + IDX_W'(1);
      if (capture)       new_frame_d = 1'b0;
      else if (idx_wrap) new_frame_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_q       <= '0;
      slot_q      <= '0;
      idx_q       <= '0;
      new_frame_q <= 1'b1;
    end else begin
      sub_q       <= sub_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      new_frame_q <= new_frame_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      shd_hex_q   <= hex_in;
      shd_dp_q    <= dp_in;
      shd_blank_q <= blank;
      shd_lz_q    <= lz_suppress;
      shd_br_q    <= brightness;
    end
  end

  // On the capture cycle the fresh inputs are used directly so slot 0 of digit 0 is not stale
  always_comb begin
    hex_e   = capture ? hex_in      : shd_hex_q;
    dp_e    = capture ? dp_in       : shd_dp_q;
    blank_e = capture ? blank       : shd_blank_q;
    lz_e    = capture ? lz_suppress : shd_lz_q;
    br_e    = capture ? brightness  : shd_br_q;
    sup     = '0;
    run     = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run    = run & (hex_e[4*i +: 4] == 4'd0) & ~dp_e[i];
      sup[i] = run & lz_e;
    end
    cur_val = hex_e[4*idx_q +: 4];
    lit     = enable && !blank_e[idx_q] && !sup[idx_q] && (slot_q < br_e);
    an_d    = lit ? (DIGITS'(1) << idx_q) : '0;
    sseg_d  = lit ? glyph(cur_val) : 7'd0;
    dp_d    = lit & dp_e[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= {DIGITS{INV}};
      sseg_q <= {7{INV}};
      dp_q   <= INV;
      ft_q   <= 1'b0;
    end else begin
      an_q   <= an_d ^ {DIGITS{INV}};
      sseg_q <= sseg_d ^ {7{INV}};
      dp_q   <= dp_d ^ INV;
      ft_q   <= capture;
    end
  end

  assign AN         = an_q;
  assign SSEG       = sseg_q;
  assign DP         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Scoreboard bench for sseg_scan_driver (DIGITS=4, PRESCALE=32, active-low outputs):
// the stimulus side predicts each registered output cycle, a negedge monitor compares.
module tb_sseg_scan_driver;

  localparam int D  = 4;
  localparam int P  = 32;
  localparam int FR = D * P;

  logic         clk = 1'b0;
  logic         reset, enable, lz_suppress;
  logic [15:0]  hex_in;
  logic [3:0]   dp_in, blank, brightness;
  logic [6:0]   SSEG;
  logic [3:0]   AN;
  logic         DP, frame_tick;

  sseg_scan_driver #(.DIGITS(D), .PRESCALE(P), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hex_in(hex_in), .dp_in(dp_in),
    .blank(blank), .lz_suppress(lz_suppress), .brightness(brightness),
    .SSEG(SSEG), .AN(AN), .DP(DP), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    logic       ft;
    int         tag;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Time-based reference: t counts enabled cycles since the last frame start
  int         t = 0;
  int         cyc = 0;
  logic [15:0] sh_hex;
  logic [3:0]  sh_dp, sh_blank, sh_br;
  logic        sh_lz;

  task automatic step();
    exp_t e;
    int   dig, slot;
    logic lead, lit;
    logic [3:0] supm, v;
    e.tag = cyc;
    e.an = 4'hF; e.sseg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
    if (reset) begin
      t = 0;
    end else if (enable) begin
      if (t % FR == 0) begin
        sh_hex = hex_in; sh_dp = dp_in; sh_blank = blank; sh_lz = lz_suppress; sh_br = brightness;
      end
      lead = 1'b1;
      for (int i = 3; i >= 0; i--) begin
        if (sh_hex[4*i +: 4] != 4'd0 || sh_dp[i]) lead = 1'b0;
        supm[i] = sh_lz && lead && (i != 0);
      end
      dig  = (t / P) % D;
      slot = (t % P) / 2;
      lit  = !sh_blank[dig] && !supm[dig] && (slot < int'(sh_br));
      v    = sh_hex[4*dig +: 4];
      if (lit) begin
        e.an   = ~(4'b0001 << dig);
        e.sseg = ~GLY[v];
        e.dp   = ~sh_dp[dig];
      end
      e.ft = (t % FR == 0);
      t++;
    end
    q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < 2 * FR && (t % FR) != phase; k++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (AN !== e.an || SSEG !== e.sseg || DP !== e.dp || frame_tick !== e.ft) begin
        miscompares++;
        $display("FAIL cycle %0d: AN=%b SSEG=%b DP=%b ft=%b, expected AN=%b SSEG=%b DP=%b ft=%b",
                 e.tag, AN, SSEG, DP, frame_tick, e.an, e.sseg, e.dp, e.ft);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; lz_suppress = 1'b0;
    hex_in = 16'h1234; dp_in = 4'b0000; blank = 4'b0000; brightness = 4'd15;
    #1;
    // Reset and plain scan
    run(3);
    reset = 1'b0;
    run(2 * FR);
    // Brightness levels
    brightness = 4'd4;  run(FR);
    brightness = 4'd0;  run(FR);
    brightness = 4'd15;
    // Leading-zero suppression
    lz_suppress = 1'b1;
    hex_in = 16'h0050; run(FR);
    hex_in = 16'h0000; run(FR);
    dp_in  = 4'b0100;  run(FR);
    // Mid-frame input change must not tear
    dp_in = 4'b0000; lz_suppress = 1'b0; hex_in = 16'h1111;
    run(40);
    hex_in = 16'h2222;
    run(FR - 40 + FR);
    // Blank, DP and enable pause
    blank = 4'b0010; run(FR);
    blank = 4'b0000; dp_in = 4'b0001; run(FR);
    dp_in = 4'b0000; run(50);
    enable = 1'b0; run(100);
    enable = 1'b1; run_to(0); run(FR);
    // Reset mid-frame
    run(70);
    reset = 1'b1; step();
    reset = 1'b0; run(200);
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It drives DIGITS common-anode digits from one packed hex bus, scanning one digit at a time at a programmable refresh rate. Beyond plain digit decoding it adds per-digit blanking, leading-zero suppression, 16-level PWM brightness, and tear-free frame-boundary input capture. It sits between the terminal's display-data registers and the board's SSEG/AN/DP pins.

## Interface
- DIGITS, 8: number of digits scanned, 2..16.
- PRESCALE, 100000: clock cycles each digit is selected; must be a multiple of 16 and at least 32.
- ACTIVE_LOW, 1: 1 means SSEG, AN and DP are active-low (board default); 0 means active-high.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high.
- enable  in  1: 0 blanks the display and freezes scanning.
- hex_in  in  4*DIGITS: digit values; digit i is hex_in[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  DIGITS: decimal point request per digit.
- blank  in  DIGITS: force digit i dark (segments, DP and anode).
- lz_suppress  in  1: enables leading-zero suppression.
- brightness  in  4: duty level 0..15.
- SSEG  out  7: segments, bit 0 = a … bit 6 = g.
- AN  out  DIGITS: digit anodes.
- DP  out  1: decimal point.
- frame_tick  out  1: one-cycle pulse at each frame start.

## Operation
**Counters**
- sub counter runs 0..PRESCALE/16−1.
- slot counter (4 bits) runs 0..15 and increments when sub wraps.
- digit index runs 0..DIGITS−1 and increments when slot wraps 15→0.
- The index wraps DIGITS−1→0.

**Frame boundary** (index wraps to 0, or first cycle after reset)
- hex_in, dp_in, blank, lz_suppress and brightness are captured into shadow registers.
- frame_tick pulses.
- No other input is sampled mid-frame.

**Leading-zero suppression** (shadow values)
- Scanning from digit DIGITS−1 downward, digit i is suppressed while it and every higher digit have value 0 and dp 0.
- Digit 0 is never suppressed.
- lz_suppress=0 disables suppression.

**Digit lit condition**
- A digit is lit when: enable=1, and not blank, and not suppressed, and slot < brightness.
- brightness 0 gives dark; 15 gives 15/16 duty.

**When lit**
- AN asserts only the selected index bit.
- SSEG shows the standard hex glyph for the shadow value. Active-high glyphs: 0=0111111, 1=0000110, 8=1111111, F=1110001.
- DP reflects shadow dp.

**When not lit**
- All AN inactive, SSEG all off, DP off.

**Polarity**
- With ACTIVE_LOW=1, all three outputs are inverted relative to the active-high glyph.

**enable=0**
- Counters and shadows hold.
- Outputs are inactive from the next cycle.
- On re-enable, scanning resumes from the held position.

## Timing
- All outputs are registered.
- Reset values (ACTIVE_LOW=1): AN all 1s, SSEG 1111111, DP 1, frame_tick 0.
- Reset values (ACTIVE_LOW=0): AN all 0s, SSEG 0000000, DP 0, frame_tick 0.
- Reset also clears all counters and the index to 0.
- Reset asserted mid-frame: reset values appear on the following edge. The shadows reload in the first cycle after reset deasserts, and frame_tick pulses there.
- Output latency: AN/SSEG/DP reflect the index/slot state one cycle after that state changes.
- Dwell: each digit is selected for exactly PRESCALE cycles.
- Frame length: DIGITS·PRESCALE cycles; frame_tick period equals the frame length while enabled.
- Simultaneous events:
  - Input change in the same cycle as the frame boundary is captured (the edge sample wins).
  - brightness changes take effect only at the next frame.
  - reset dominates enable.

## Test plan
Bench parameters: DIGITS=4, PRESCALE=32, ACTIVE_LOW=1.

1. **Reset/scan.** reset 3 cycles, hex_in=0x1234, brightness=15, enable=1.
   - After reset: AN=1111.
   - Then AN cycles 1110→1101→1011→0111, each for 32 cycles (30 lit, 2 dark per slot rule).
   - SSEG shows 4,3,2,1 in that order.
   - frame_tick fires every 128 cycles.
2. **Brightness.** brightness=4.
   - Each digit's AN is active for exactly 8 of 32 cycles, in 4 contiguous 2-cycle slots.
   - brightness=0 → AN stays 1111 for a full frame.
3. **Leading zeros.** hex_in=0x0050, lz_suppress=1.
   - Digits 3 and 2 stay dark; digits 1 (5) and 0 (0) are lit.
   - hex_in=0x0000 → only digit 0 is lit.
   - dp_in=0100 with 0x0000 → digits 2..0 are lit.
4. **Tear-free capture.** Change hex_in from 0x1111 to 0x2222 mid-frame (cycle 40).
   - The remainder of that frame still shows 1.
   - The next frame shows 2.
5. **Blank/DP/enable.**
   - blank=0010 → digit 1 stays dark.
   - dp_in=0001 → DP=0 only while digit 0 is lit.
   - enable=0 for 100 cycles → outputs inactive; scanning resumes at the same index.
6. **Reset mid-frame.** Assert reset at cycle 70.
   - Next edge: reset values.
   - After release, scanning restarts at digit 0 and frame_tick pulses once.
